uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, transmit holding FIFO entries (power of two, >=2).
REQ-002 SHALL have input i_Clock, 1 bit: clock; all state updates on rising edge.
REQ-003 SHALL have input i_Rst_L, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have input i_Cmd_En, 1 bit: one-cycle pulse that enables the transmitter.
REQ-005 SHALL have input i_Cmd_Dis, 1 bit: one-cycle pulse that disables the transmitter.
REQ-006 SHALL have input i_Cmd_Rst, 1 bit: one-cycle pulse that resets the transmitter channel.
REQ-007 SHALL have input i_Wr, 1 bit: one-cycle host write strobe.
REQ-008 SHALL have input i_Wr_Data, 8 bits: host write byte.
REQ-009 SHALL have output o_TxRDY, 1 bit: FIFO can accept a byte.
REQ-010 SHALL have output o_TxEMT, 1 bit: FIFO empty and serializer idle.
REQ-011 SHALL have output o_Ovr_Err, 1 bit: sticky write-while-full flag.
REQ-012 SHALL have output o_TX_DV, 1 bit: one-cycle launch strobe to the serializer.
REQ-013 SHALL have output o_TX_Byte, 8 bits: byte for the serializer, valid with o_TX_DV.
REQ-014 SHALL have input i_TX_Done, 1 bit: serializer one-cycle completion pulse, one cycle before the serializer returns to idle.

Function
REQ-015 SHALL hold an enable flag: set by i_Cmd_En; cleared by i_Cmd_Dis or i_Cmd_Rst.
REQ-016 SHALL give same-cycle command priority i_Cmd_Rst > i_Cmd_Dis > i_Cmd_En.
REQ-017 SHALL drive o_TxRDY = enable AND FIFO not full, registered, updated the cycle after the causing event.
REQ-018 SHALL push i_Wr_Data on i_Wr when enable=1 and the FIFO is not full; visible in FIFO count next cycle.
REQ-019 SHALL accept i_Wr when the FIFO is full and a pop occurs in the same cycle; the count stays FIFO_DEPTH.
REQ-020 SHALL drop i_Wr when the FIFO is full with no same-cycle pop, and set o_Ovr_Err; o_Ovr_Err is cleared only by i_Cmd_Rst or reset.
REQ-021 SHALL ignore i_Wr while enable=0, with no store and no o_Ovr_Err.
REQ-022 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH and keep a count 0..FIFO_DEPTH; full is count=FIFO_DEPTH, empty is count=0.
REQ-023 SHALL implement FSM states IDLE, LAUNCH, WAIT_DONE, GAP.
REQ-024 SHALL move from IDLE to LAUNCH when the FIFO is non-empty, regardless of enable, so bytes queued before a disable still drain.
REQ-025 SHALL, in LAUNCH, assert o_TX_DV for exactly one cycle with o_TX_Byte = FIFO head, pop the FIFO in that cycle, and go to WAIT_DONE.
REQ-026 SHALL stay in WAIT_DONE until i_TX_Done=1, then go to GAP.
REQ-027 SHALL spend exactly one cycle in GAP, then go to IDLE; this guarantees the serializer is idle before the next o_TX_DV.
REQ-028 SHALL keep o_TX_DV=0 in every state except LAUNCH, and hold o_TX_Byte stable from LAUNCH until the next LAUNCH.
REQ-029 SHALL ignore i_TX_Done outside WAIT_DONE.
REQ-030 SHALL drive o_TxEMT = (state=IDLE AND FIFO empty), registered.
REQ-031 SHALL, on i_Cmd_Rst: flush the FIFO (pointers and count to 0), clear enable and o_Ovr_Err, and return the FSM to IDLE from IDLE or LAUNCH.
REQ-032 SHALL, on i_Cmd_Rst in LAUNCH, suppress o_TX_DV in that cycle.
REQ-033 SHALL, on i_Cmd_Rst in WAIT_DONE or GAP, leave the FSM unchanged so the byte in flight completes and the serializer is not re-launched while busy.
REQ-034 SHALL let a byte written in the same cycle as i_Cmd_Rst be dropped.
REQ-035 SHALL, on i_Cmd_Dis, leave the FSM and FIFO contents untouched; all queued bytes are transmitted, then o_TxEMT=1.
REQ-036 SHALL give a minimum write-to-o_TX_DV latency of 2 cycles for an idle, empty controller: write at cycle n, IDLE sees non-empty at n+1, LAUNCH at n+2.

Reset
REQ-037 SHALL, while i_Rst_L=0 and independent of i_Clock, force state=IDLE, enable=0, FIFO empty, o_TxRDY=0, o_TxEMT=1, o_Ovr_Err=0, o_TX_DV=0, o_TX_Byte=8'h00.
REQ-038 SHALL resume operation on the first rising edge after i_Rst_L deasserts; the enable flag stays 0 until i_Cmd_En.

Verification
REQ-039 SHALL cover: reset, i_Cmd_En, write 8'hA5 -> o_TX_DV pulses once with o_TX_Byte=8'hA5 two cycles later, o_TxEMT=0 until GAP->IDLE after i_TX_Done.
REQ-040 SHALL cover: enabled, write 5 bytes back-to-back with FIFO_DEPTH=4 and serializer busy -> first 4 stored (or 5 if a pop overlaps), o_TxRDY=0 when full, the overflowing write sets o_Ovr_Err=1, and order is preserved on o_TX_Byte.
REQ-041 SHALL cover: 3 bytes queued, then i_Cmd_Dis -> o_TxRDY=0 next cycle, all 3 bytes still launched, o_TxEMT=1 afterwards, and further writes ignored.
REQ-042 SHALL cover: i_Cmd_Rst during WAIT_DONE with 2 bytes queued -> FIFO flushed, no further o_TX_DV, FSM waits for i_TX_Done, then o_TxEMT=1 after GAP.
REQ-043 SHALL cover: same-cycle i_Cmd_En and i_Cmd_Dis -> enable=0; same-cycle write and pop at full -> count stays 4, o_Ovr_Err stays 0.
REQ-044 SHALL cover: i_Rst_L asserted mid-WAIT_DONE -> all outputs take reset values without a clock edge; a stray i_TX_Done after reset is ignored.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// Transmit controller: holds host bytes in a small FIFO and hands them one
// at a time to a UART serializer, waiting for its completion pulse plus one
// idle cycle before launching the next byte.
module uart_tx_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Cmd_En,
  input  logic       i_Cmd_Dis,
  input  logic       i_Cmd_Rst,
  input  logic       i_Wr,
  input  logic [7:0] i_Wr_Data,
  output logic       o_TxRDY,
  output logic       o_TxEMT,
  output logic       o_Ovr_Err,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  input  logic       i_TX_Done
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitDone, StGap} state_e;

  state_e            state_q, state_d;
  logic              enable_q, enable_d;
  logic              ovr_q, ovr_d;
  logic              tx_rdy_q;
  logic              tx_emt_q;
  logic [7:0]        byte_q;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic full, pop, push, overflow;

  // FIFO handshake: a pop in LAUNCH frees a slot for a same-cycle write at full
  always_comb begin
    full     = (count_q == CntW'(FIFO_DEPTH));
    pop      = (state_q == StLaunch) && !i_Cmd_Rst;
    push     = i_Wr && enable_q && !i_Cmd_Rst && (!full || pop);
    overflow = i_Wr && enable_q && !i_Cmd_Rst && full && !pop;
  end

  // Enable flag, sticky overrun and FIFO bookkeeping next-state
  always_comb begin
    enable_d = enable_q;
    ovr_d    = ovr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_Cmd_Rst) begin
      enable_d = 1'b0;
      ovr_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (i_Cmd_Dis) begin
        enable_d = 1'b0;
      end else if (i_Cmd_En) begin
        enable_d = 1'b1;
      end
      if (overflow) begin
        ovr_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Launch sequencer; a channel reset cannot abort a byte already in flight
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && !i_Cmd_Rst) begin
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        state_d = i_Cmd_Rst ? StIdle : StWaitDone;
      end
      StWaitDone: begin
        if (i_TX_Done) begin
          state_d = StGap;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and registered status flags
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= StIdle;
      enable_q <= 1'b0;
      ovr_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_rdy_q <= 1'b0;
      tx_emt_q <= 1'b1;
      byte_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      ovr_q    <= ovr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Flags computed from next-state so they track the state they describe
      tx_rdy_q <= enable_d && (count_d != CntW'(FIFO_DEPTH));
      tx_emt_q <= (state_d == StIdle) && (count_d == '0);
      if (pop) begin
        byte_q <= mem[rd_ptr_q];
      end
    end
  end

  // FIFO storage; contents need no reset since the count qualifies them
  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem[wr_ptr_q] <= i_Wr_Data;
    end
  end

  // Byte shown live in LAUNCH, then held until the next launch
  always_comb begin
    o_TX_DV   = pop;
    o_TX_Byte = pop ? mem[rd_ptr_q] : byte_q;
    o_TxRDY   = tx_rdy_q;
    o_TxEMT   = tx_emt_q;
    o_Ovr_Err = ovr_q;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a scoreboard of bytes expected on the
// serializer side plus a small serializer model returning completion pulses.
module tb_uart_tx_ctrl;

  logic       i_Clock;
  logic       i_Rst_L;
  logic       i_Cmd_En, i_Cmd_Dis, i_Cmd_Rst;
  logic       i_Wr;
  logic [7:0] i_Wr_Data;
  logic       o_TxRDY, o_TxEMT, o_Ovr_Err, o_TX_DV;
  logic [7:0] o_TX_Byte;
  logic       tx_done, auto_done, man_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];
  int dv_count = 0;
  bit ser_busy = 0;
  bit ser_auto = 1;
  int ser_cnt = 0;
  int ser_lat = 2;
  int dv_base;

  assign tx_done = auto_done | man_done;

  uart_tx_ctrl #(.FIFO_DEPTH(4)) dut (
    .i_Clock   (i_Clock),
    .i_Rst_L   (i_Rst_L),
    .i_Cmd_En  (i_Cmd_En),
    .i_Cmd_Dis (i_Cmd_Dis),
    .i_Cmd_Rst (i_Cmd_Rst),
    .i_Wr      (i_Wr),
    .i_Wr_Data (i_Wr_Data),
    .o_TxRDY   (o_TxRDY),
    .o_TxEMT   (o_TxEMT),
    .o_Ovr_Err (o_Ovr_Err),
    .o_TX_DV   (o_TX_DV),
    .o_TX_Byte (o_TX_Byte),
    .i_TX_Done (tx_done)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic cmd(input bit en, input bit dis, input bit rst);
    i_Cmd_En  = en;
    i_Cmd_Dis = dis;
    i_Cmd_Rst = rst;
    cyc();
    i_Cmd_En  = 1'b0;
    i_Cmd_Dis = 1'b0;
    i_Cmd_Rst = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d, input bit expect_tx);
    i_Wr      = 1'b1;
    i_Wr_Data = d;
    if (expect_tx) sb.push_back(d);
    cyc();
    i_Wr = 1'b0;
  endtask

  task automatic done_pulse();
    man_done = 1'b1;
    cyc();
    man_done = 1'b0;
  endtask

  task automatic wait_dv(input string tag);
    int n = 0;
    while (!o_TX_DV && n < 50) begin
      cyc();
      n++;
    end
    check_eq(tag, 32'(o_TX_DV), 1);
  endtask

  task automatic wait_emt(input string tag);
    int n = 0;
    while (!o_TxEMT && n < 200) begin
      cyc();
      n++;
    end
    check_eq(tag, 32'(o_TxEMT), 1);
  endtask

  // Serializer model and output scoreboard, sampled on the falling edge
  initial begin
    auto_done = 1'b0;
    forever begin
      @(negedge i_Clock);
      if (!i_Rst_L) begin
        ser_busy  = 0;
        auto_done = 1'b0;
      end else if (tx_done) begin
        ser_busy = 0;
        if (ser_auto) auto_done = 1'b0;
      end else if (ser_busy && ser_auto) begin
        if (ser_cnt == 0) auto_done = 1'b1;
        else ser_cnt--;
      end
      if (o_TX_DV) begin
        dv_count++;
        check_eq("dv_while_busy", 32'(ser_busy), 0);
        if (sb.size() == 0) check_eq("sb_underflow", 32'(sb.size()), 1);
        else check_eq("tx_byte_order", 32'(o_TX_Byte), 32'(sb.pop_front()));
        ser_busy = 1;
        ser_cnt  = ser_lat;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_Rst_L = 1'b1;
    i_Cmd_En = 1'b0; i_Cmd_Dis = 1'b0; i_Cmd_Rst = 1'b0;
    i_Wr = 1'b0; i_Wr_Data = 8'h00; man_done = 1'b0;
    #2 i_Rst_L = 1'b0;
    #1;
    check_eq("rst_txrdy", 32'(o_TxRDY), 0);
    check_eq("rst_txemt", 32'(o_TxEMT), 1);
    check_eq("rst_ovr", 32'(o_Ovr_Err), 0);
    check_eq("rst_dv", 32'(o_TX_DV), 0);
    check_eq("rst_byte", 32'(o_TX_Byte), 0);
    repeat (2) cyc();
    i_Rst_L = 1'b1;
    cyc();
    check_eq("post_rst_txrdy", 32'(o_TxRDY), 0);

    // Single byte, minimum launch latency
    cmd(1, 0, 0);
    check_eq("en_txrdy", 32'(o_TxRDY), 1);
    dv_base = dv_count;
    wr(8'hA5, 1);
    check_eq("a5_emt_low", 32'(o_TxEMT), 0);
    check_eq("a5_dv_n1", 32'(o_TX_DV), 0);
    cyc();
    check_eq("a5_dv_n2", 32'(o_TX_DV), 1);
    check_eq("a5_byte", 32'(o_TX_Byte), 32'h A5);
    cyc();
    check_eq("a5_dv_oneshot", 32'(o_TX_DV), 0);
    check_eq("a5_byte_hold", 32'(o_TX_Byte), 32'h A5);
    wait_emt("a5_emt_timeout");
    check_eq("a5_dv_count", 32'(dv_count - dv_base), 1);

    // Fill while serializer busy, then overflow
    ser_auto = 0;
    dv_base = dv_count;
    wr(8'h10, 1);
    wait_dv("fill_first_dv");
    cyc();
    for (int i = 0; i < 5; i++) begin
      wr(8'h11 * 8'(i + 1), i < 4);
      if (i == 3) begin
        check_eq("full_txrdy", 32'(o_TxRDY), 0);
        check_eq("full_no_ovr", 32'(o_Ovr_Err), 0);
      end
    end
    check_eq("ovr_set", 32'(o_Ovr_Err), 1);
    ser_auto = 1;
    cyc();
    wait_emt("fill_emt_timeout");
    check_eq("fill_dv_count", 32'(dv_count - dv_base), 5);
    check_eq("fill_txrdy_back", 32'(o_TxRDY), 1);
    check_eq("ovr_sticky", 32'(o_Ovr_Err), 1);

    // Channel reset clears overrun; En+Dis together leaves disabled
    cmd(0, 0, 1);
    check_eq("crst_ovr", 32'(o_Ovr_Err), 0);
    check_eq("crst_txrdy", 32'(o_TxRDY), 0);
    cmd(1, 1, 0);
    check_eq("endis_txrdy", 32'(o_TxRDY), 0);
    dv_base = dv_count;
    wr(8'hEE, 0);
    repeat (4) cyc();
    check_eq("dis_wr_no_dv", 32'(dv_count - dv_base), 0);
    check_eq("dis_wr_emt", 32'(o_TxEMT), 1);
    check_eq("dis_wr_no_ovr", 32'(o_Ovr_Err), 0);

    // Write at full in the same cycle as the pop
    cmd(1, 0, 0);
    check_eq("reen_txrdy", 32'(o_TxRDY), 1);
    ser_auto = 0;
    dv_base = dv_count;
    wr(8'h20, 1);
    wait_dv("popfull_first_dv");
    cyc();
    for (int i = 1; i <= 4; i++) wr(8'h20 + 8'(i), 1);
    check_eq("popfull_full", 32'(o_TxRDY), 0);
    done_pulse();
    cyc();
    cyc();
    check_eq("popfull_launch", 32'(o_TX_DV), 1);
    wr(8'h25, 1);
    check_eq("popfull_txrdy", 32'(o_TxRDY), 0);
    check_eq("popfull_no_ovr", 32'(o_Ovr_Err), 0);
    ser_auto = 1;
    wait_emt("popfull_emt_timeout");
    check_eq("popfull_dv_count", 32'(dv_count - dv_base), 6);

    // Disable with bytes queued: they still drain
    ser_auto = 0;
    dv_base = dv_count;
    wr(8'h31, 1);
    wr(8'h32, 1);
    wr(8'h33, 1);
    cmd(0, 1, 0);
    check_eq("dis_txrdy", 32'(o_TxRDY), 0);
    wr(8'h3F, 0);
    check_eq("dis_ovr", 32'(o_Ovr_Err), 0);
    ser_auto = 1;
    wait_emt("dis_emt_timeout");
    check_eq("dis_dv_count", 32'(dv_count - dv_base), 3);

    // Channel reset while a byte is in flight
    cmd(1, 0, 0);
    ser_auto = 0;
    dv_base = dv_count;
    wr(8'h41, 1);
    wr(8'h42, 0);
    wr(8'h43, 0);
    cyc();
    cmd(0, 0, 1);
    check_eq("crst_wait_emt", 32'(o_TxEMT), 0);
    check_eq("crst_wait_txrdy", 32'(o_TxRDY), 0);
    repeat (5) cyc();
    check_eq("crst_no_relaunch", 32'(dv_count - dv_base), 1);
    done_pulse();
    check_eq("crst_gap_emt", 32'(o_TxEMT), 0);
    cyc();
    check_eq("crst_idle_emt", 32'(o_TxEMT), 1);
    repeat (3) cyc();
    check_eq("crst_dv_count", 32'(dv_count - dv_base), 1);

    // Asynchronous reset in WAIT_DONE with overrun and a full FIFO
    cmd(1, 0, 0);
    ser_auto = 0;
    dv_base = dv_count;
    wr(8'h51, 1);
    wait_dv("arst_first_dv");
    cyc();
    for (int i = 2; i <= 6; i++) wr(8'h50 + 8'(i), 0);
    check_eq("arst_pre_ovr", 32'(o_Ovr_Err), 1);
    @(posedge i_Clock);
    #3 i_Rst_L = 1'b0;
    #1;
    check_eq("arst_txrdy", 32'(o_TxRDY), 0);
    check_eq("arst_txemt", 32'(o_TxEMT), 1);
    check_eq("arst_ovr", 32'(o_Ovr_Err), 0);
    check_eq("arst_dv", 32'(o_TX_DV), 0);
    check_eq("arst_byte", 32'(o_TX_Byte), 0);
    repeat (2) cyc();
    i_Rst_L = 1'b1;
    cyc();
    done_pulse();
    repeat (3) cyc();
    check_eq("stray_done_emt", 32'(o_TxEMT), 1);
    check_eq("stray_done_no_dv", 32'(dv_count - dv_base), 1);
    check_eq("arst_en_cleared", 32'(o_TxRDY), 0);
    cmd(1, 0, 0);
    ser_auto = 1;
    wr(8'h57, 1);
    wait_emt("arst_resume_emt");
    check_eq("arst_resume_dv", 32'(dv_count - dv_base), 2);

    check_eq("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
